// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline freeze/flush scheduler.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 4;

  // Encodings kept identical to the legacy 2-bit state register.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  // Instruction word loaded into ID/EX when a bubble is inserted (addi x0,x0,0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals seen by the hazard controller; the controller takes the slave view.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_two_src;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  ex_wb_en;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  branch_taken;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  if_freeze;
  logic                  if_flush;
  logic                  id_bubble;
  logic                  pipe_freeze;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, ex_dest, ex_wb_en, ex_mem_read,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    input  if_freeze, if_flush, id_bubble, pipe_freeze, mem_timeout, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, ex_dest, ex_wb_en, ex_mem_read,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    output if_freeze, if_flush, id_bubble, pipe_freeze, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW / load-use detection of the ID operands against EX and MEM.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter bit          FWD_EN     = 1'b1
) (
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_src1_i,
  input  logic [REG_ADDR_W-1:0] id_src2_i,
  input  logic                  id_two_src_i,
  input  logic [REG_ADDR_W-1:0] ex_dest_i,
  input  logic                  ex_wb_en_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] mem_dest_i,
  input  logic                  mem_wb_en_i,
  output logic                  hazard_o
);
  logic match_ex;
  logic match_mem;

  always_comb begin
    match_ex  = ex_wb_en_i &
                ((id_src1_i == ex_dest_i) | (id_two_src_i & (id_src2_i == ex_dest_i)));
    match_mem = mem_wb_en_i &
                ((id_src1_i == mem_dest_i) | (id_two_src_i & (id_src2_i == mem_dest_i)));
    // With forwarding only a load in EX cannot be bypassed in time.
    hazard_o  = id_valid_i &
                ((match_ex & (ex_mem_read_i | ~FWD_EN)) | (match_mem & ~FWD_EN));
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Freeze/flush scheduler: hazard stalls, branch flushes (deferred across memory stalls),
// memory-wait FSM with timeout, and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter bit          FWD_EN       = 1'b1,
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned WCNT_W = $clog2(MEM_WAIT_MAX + 1);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               hazard;
  logic               pipe_freeze;
  logic               if_freeze;
  logic               if_flush;
  logic               id_bubble;

  pipe_hazard_ctrl_hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_EN     (FWD_EN)
  ) u_hazard_detect (
    .id_valid_i    (bus.id_valid),
    .id_src1_i     (bus.id_src1),
    .id_src2_i     (bus.id_src2),
    .id_two_src_i  (bus.id_two_src),
    .ex_dest_i     (bus.ex_dest),
    .ex_wb_en_i    (bus.ex_wb_en),
    .ex_mem_read_i (bus.ex_mem_read),
    .mem_dest_i    (bus.mem_dest),
    .mem_wb_en_i   (bus.mem_wb_en),
    .hazard_o      (hazard)
  );

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_req && !bus.mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_W'(MEM_WAIT_MAX)) begin
          state_d       = ST_ERR;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // MEM_WAIT releases the freeze combinationally in the cycle mem_ready arrives.
  assign pipe_freeze = ((state_q == ST_IDLE) && bus.mem_req && !bus.mem_ready) ||
                       ((state_q == ST_MEM_WAIT) && !bus.mem_ready) ||
                       (state_q == ST_ERR);

  always_comb begin
    if_freeze    = 1'b0;
    if_flush     = 1'b0;
    id_bubble    = 1'b0;
    flush_pend_d = 1'b0;
    if (pipe_freeze) begin
      flush_pend_d = flush_pend_q | bus.branch_taken;
    end else if (bus.branch_taken || flush_pend_q) begin
      if_flush  = 1'b1;
      id_bubble = 1'b1;
    end else if (hazard) begin
      if_freeze = 1'b1;
      id_bubble = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((pipe_freeze || if_freeze) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      flush_pend_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      flush_pend_q  <= flush_pend_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.if_freeze   = if_freeze;
  assign bus.if_flush    = if_flush;
  assign bus.id_bubble   = id_bubble;
  assign bus.pipe_freeze = pipe_freeze;
  assign bus.mem_timeout = mem_timeout_q;
  assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a forwarding build (CNT_W=16) and a non-forwarding build
// (CNT_W=4) share one directed stimulus and are checked against a behavioural model.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_two_src, ex_wb_en, ex_mem_read, mem_wb_en;
  logic       branch_taken, mem_req, mem_ready;
  logic [3:0] id_src1, id_src2, ex_dest, mem_dest;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(16)) bus_f ();
  pipe_hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(4))  bus_n ();

  assign bus_f.id_valid = id_valid;         assign bus_n.id_valid = id_valid;
  assign bus_f.id_src1 = id_src1;           assign bus_n.id_src1 = id_src1;
  assign bus_f.id_src2 = id_src2;           assign bus_n.id_src2 = id_src2;
  assign bus_f.id_two_src = id_two_src;     assign bus_n.id_two_src = id_two_src;
  assign bus_f.ex_dest = ex_dest;           assign bus_n.ex_dest = ex_dest;
  assign bus_f.ex_wb_en = ex_wb_en;         assign bus_n.ex_wb_en = ex_wb_en;
  assign bus_f.ex_mem_read = ex_mem_read;   assign bus_n.ex_mem_read = ex_mem_read;
  assign bus_f.mem_dest = mem_dest;         assign bus_n.mem_dest = mem_dest;
  assign bus_f.mem_wb_en = mem_wb_en;       assign bus_n.mem_wb_en = mem_wb_en;
  assign bus_f.branch_taken = branch_taken; assign bus_n.branch_taken = branch_taken;
  assign bus_f.mem_req = mem_req;           assign bus_n.mem_req = mem_req;
  assign bus_f.mem_ready = mem_ready;       assign bus_n.mem_ready = mem_ready;

  pipe_hazard_ctrl #(
    .REG_ADDR_W(4), .FWD_EN(1'b1), .MEM_WAIT_MAX(15), .CNT_W(16)
  ) u_fwd (.clk(clk), .rst(rst), .bus(bus_f));

  pipe_hazard_ctrl #(
    .REG_ADDR_W(4), .FWD_EN(1'b0), .MEM_WAIT_MAX(15), .CNT_W(4)
  ) u_nofwd (.clk(clk), .rst(rst), .bus(bus_n));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access outstanding for more than 15 wait cycles locks the pipe until reset.
  bit m_valid = 0;
  bit m_stuck, m_pend;
  int m_out, m_cnt_f, m_cnt_n;

  function automatic bit model_hazard(input bit fwd);
    bit on_ex, on_mem;
    if (!id_valid) return 1'b0;
    on_ex  = ex_wb_en && (id_src1 == ex_dest || (id_two_src && id_src2 == ex_dest));
    on_mem = mem_wb_en && (id_src1 == mem_dest || (id_two_src && id_src2 == mem_dest));
    return fwd ? (on_ex && ex_mem_read) : (on_ex || on_mem);
  endfunction

  always @(negedge clk) begin
    bit frz, flush, hz_f, hz_n;
    bit e_frz_f, e_frz_n;
    frz   = m_stuck || (m_out > 0 ? !mem_ready : (mem_req && !mem_ready));
    flush = !frz && (branch_taken || m_pend);
    hz_f  = model_hazard(1'b1);
    hz_n  = model_hazard(1'b0);
    e_frz_f = !frz && !flush && hz_f;
    e_frz_n = !frz && !flush && hz_n;
    if (m_valid) begin
      check("fwd.pipe_freeze", 32'(bus_f.pipe_freeze), 32'(frz));
      check("fwd.if_flush",    32'(bus_f.if_flush),    32'(flush));
      check("fwd.if_freeze",   32'(bus_f.if_freeze),   32'(e_frz_f));
      check("fwd.id_bubble",   32'(bus_f.id_bubble),   32'(flush || e_frz_f));
      check("fwd.mem_timeout", 32'(bus_f.mem_timeout), 32'(m_stuck));
      check("fwd.stall_cnt",   32'(bus_f.stall_cnt),   32'(m_cnt_f));
      check("nofwd.pipe_freeze", 32'(bus_n.pipe_freeze), 32'(frz));
      check("nofwd.if_flush",    32'(bus_n.if_flush),    32'(flush));
      check("nofwd.if_freeze",   32'(bus_n.if_freeze),   32'(e_frz_n));
      check("nofwd.id_bubble",   32'(bus_n.id_bubble),   32'(flush || e_frz_n));
      check("nofwd.mem_timeout", 32'(bus_n.mem_timeout), 32'(m_stuck));
      check("nofwd.stall_cnt",   32'(bus_n.stall_cnt),   32'(m_cnt_n));
    end
    if (rst) begin
      m_valid = 1; m_stuck = 0; m_pend = 0; m_out = 0; m_cnt_f = 0; m_cnt_n = 0;
    end else if (m_valid) begin
      m_pend = frz && (m_pend || branch_taken);
      if ((frz || e_frz_f) && m_cnt_f < 65535) m_cnt_f++;
      if ((frz || e_frz_n) && m_cnt_n < 15) m_cnt_n++;
      if (!m_stuck) begin
        if (m_out > 0) begin
          if (mem_ready) m_out = 0;
          else if (m_out == 15) m_stuck = 1;
          else m_out++;
        end else if (mem_req && !mem_ready) begin
          m_out = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    ex_dest = 0; ex_wb_en = 0; ex_mem_read = 0;
    mem_dest = 0; mem_wb_en = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic pulse_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    tick();
    tick();
    rst = 0;

    @(negedge clk);
    check("reset.if_freeze",   32'(bus_f.if_freeze),   0);
    check("reset.if_flush",    32'(bus_f.if_flush),    0);
    check("reset.id_bubble",   32'(bus_f.id_bubble),   0);
    check("reset.pipe_freeze", 32'(bus_f.pipe_freeze), 0);
    check("reset.mem_timeout", 32'(bus_f.mem_timeout), 0);
    check("reset.stall_cnt",   32'(bus_f.stall_cnt),   0);

    tick();
    ex_wb_en = 1; ex_mem_read = 1; ex_dest = 3; id_valid = 1; id_src1 = 3;
    @(negedge clk);
    check("loaduse.if_freeze", 32'(bus_f.if_freeze), 1);
    check("loaduse.id_bubble", 32'(bus_f.id_bubble), 1);
    check("loaduse.if_flush",  32'(bus_f.if_flush),  0);

    tick();
    ex_mem_read = 0;
    @(negedge clk);
    check("alu_fwd.if_freeze",   32'(bus_f.if_freeze), 0);
    check("alu_fwd.id_bubble",   32'(bus_f.id_bubble), 0);
    check("alu_nofwd.if_freeze", 32'(bus_n.if_freeze), 1);

    tick();
    idle();
    mem_wb_en = 1; mem_dest = 5; id_valid = 1; id_two_src = 1; id_src2 = 5;
    @(negedge clk);
    check("src2mem_nofwd.if_freeze", 32'(bus_n.if_freeze), 1);
    check("src2mem_fwd.if_freeze",   32'(bus_f.if_freeze), 0);

    tick();
    id_two_src = 0;
    @(negedge clk);
    check("onesrc_nofwd.if_freeze", 32'(bus_n.if_freeze), 0);

    tick();
    idle();
    ex_wb_en = 1; ex_mem_read = 1; ex_dest = 3; id_valid = 1; id_src1 = 3; branch_taken = 1;
    @(negedge clk);
    check("br_over_hz.if_flush",  32'(bus_f.if_flush),  1);
    check("br_over_hz.id_bubble", 32'(bus_f.id_bubble), 1);
    check("br_over_hz.if_freeze", 32'(bus_f.if_freeze), 0);

    tick();
    idle();
    pulse_reset();
    mem_req = 1;
    @(negedge clk);
    check("wait1.pipe_freeze", 32'(bus_f.pipe_freeze), 1);
    tick();
    branch_taken = 1;
    @(negedge clk);
    check("wait2.pipe_freeze", 32'(bus_f.pipe_freeze), 1);
    check("wait2.if_flush",    32'(bus_f.if_flush),    0);
    tick();
    branch_taken = 0;
    @(negedge clk);
    check("wait3.pipe_freeze", 32'(bus_f.pipe_freeze), 1);
    check("wait3.if_flush",    32'(bus_f.if_flush),    0);
    tick();
    mem_ready = 1;
    @(negedge clk);
    check("ready.pipe_freeze", 32'(bus_f.pipe_freeze), 0);
    check("ready.if_flush",    32'(bus_f.if_flush),    1);
    check("ready.id_bubble",   32'(bus_f.id_bubble),   1);
    tick();
    mem_req = 0; mem_ready = 0;
    @(negedge clk);
    check("after.if_flush",  32'(bus_f.if_flush),  0);
    check("after.stall_cnt", 32'(bus_f.stall_cnt), 3);

    tick();
    pulse_reset();
    mem_req = 1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("tmo_pre.mem_timeout", 32'(bus_f.mem_timeout), 0);
    check("tmo_pre.pipe_freeze", 32'(bus_f.pipe_freeze), 1);
    @(negedge clk);
    check("tmo.mem_timeout", 32'(bus_f.mem_timeout), 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("tmo.stall_cnt16", 32'(bus_f.stall_cnt), 20);
    check("tmo.stall_cnt4",  32'(bus_n.stall_cnt), 15);
    tick();
    mem_req = 0;
    @(negedge clk);
    check("err.pipe_freeze", 32'(bus_f.pipe_freeze), 1);
    check("err.mem_timeout", 32'(bus_f.mem_timeout), 1);
    check("err.stall_cnt4",  32'(bus_n.stall_cnt),   15);
    tick();
    pulse_reset();
    @(negedge clk);
    check("clr.mem_timeout", 32'(bus_f.mem_timeout), 0);
    check("clr.pipe_freeze", 32'(bus_f.pipe_freeze), 0);
    check("clr.stall_cnt16", 32'(bus_f.stall_cnt),   0);
    check("clr.stall_cnt4",  32'(bus_n.stall_cnt),   0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central freeze/flush scheduler for the 5-stage pipeline. Drives the freeze and flush inputs of the IF/ID register, the bubble insertion into ID/EX, and a global pipeline freeze during multi-cycle data-memory accesses. Combines load-use/RAW hazard detection, branch-flush sequencing (including flushes deferred across memory stalls), a memory-wait FSM with timeout, and a stall performance counter.

Parameters:
REG_ADDR_W, 4, register-file address width
FWD_EN, 1, 1 = forwarding unit present (stall only on load-use); 0 = stall on any RAW against EX or MEM
MEM_WAIT_MAX, 15, max wait cycles for mem_ready before timeout
CNT_W, 16, stall performance counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_src1  in  REG_ADDR_W  ID source register 1
id_src2  in  REG_ADDR_W  ID source register 2
id_two_src  in  1  id_src2 is a real operand
ex_dest  in  REG_ADDR_W  EX-stage destination
ex_wb_en  in  1  EX-stage instruction writes back
ex_mem_read  in  1  EX-stage instruction is a load
mem_dest  in  REG_ADDR_W  MEM-stage destination
mem_wb_en  in  1  MEM-stage instruction writes back
branch_taken  in  1  EX resolved a taken branch this cycle
mem_req  in  1  MEM stage requests external memory
mem_ready  in  1  external memory access complete
if_freeze  out  1  hold PC and IF/ID register
if_flush  out  1  clear IF/ID register
id_bubble  out  1  load NOP into ID/EX
pipe_freeze  out  1  hold all pipeline registers
mem_timeout  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  cycles with any freeze asserted, saturating

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE, wait_cnt=0, flush_pend=0, mem_timeout=0, stall_cnt=0. Combinational outputs are 0 when inputs are idle.
- FSM states: IDLE, MEM_WAIT, ERR.
  - IDLE: mem_req & ~mem_ready -> MEM_WAIT, wait_cnt=1. mem_req & mem_ready -> stay (zero-wait access, no freeze).
  - MEM_WAIT: mem_ready -> IDLE, wait_cnt=0. Else if wait_cnt==MEM_WAIT_MAX -> ERR, mem_timeout=1. Else wait_cnt++.
  - ERR: terminal until rst; pipe_freeze=1 held.
- pipe_freeze (combinational) = (IDLE & mem_req & ~mem_ready) | MEM_WAIT | ERR. In MEM_WAIT, deasserts in the same cycle mem_ready=1.
- Hazard detect (combinational, valid only when id_valid): match_ex = ex_wb_en & (id_src1==ex_dest | id_two_src & id_src2==ex_dest); match_mem is the same using mem_*. FWD_EN=1: hazard = match_ex & ex_mem_read. FWD_EN=0: hazard = match_ex | match_mem.
- Branch: flush_req = branch_taken | flush_pend.
- Priority, evaluated per cycle:
  1. pipe_freeze=1: if_freeze=0, if_flush=0, id_bubble=0. If branch_taken, set flush_pend=1.
  2. Else if flush_req: if_flush=1, id_bubble=1, if_freeze=0. Clear flush_pend next edge.
  3. Else if hazard: if_freeze=1, id_bubble=1, if_flush=0.
  4. Else all 0.
- flush_pend is set only while frozen and cleared on the first unfrozen cycle.
- stall_cnt increments on every cycle with pipe_freeze|if_freeze and saturates at all-ones.
- rst during MEM_WAIT or ERR returns to IDLE on that edge and clears mem_timeout.

Decomposition:
- Shared header/package: REG_ADDR_W default, FSM state encodings (IDLE=2'd0, MEM_WAIT=2'd1, ERR=2'd2), NOP encoding used for bubbles.
- One sub-module: hazard_detect (purely combinational match logic, parameterised by FWD_EN). FSM, flush_pend and counters remain in the top module.

Test Plan:
- FWD_EN=1; ex_mem_read=1, ex_wb_en=1, ex_dest=3; id_valid=1, id_src1=3 -> if_freeze=1, id_bubble=1 same cycle. Non-load with the same match -> all outputs 0.
- FWD_EN=0; mem_wb_en=1, mem_dest=5, id_two_src=1, id_src2=5 -> if_freeze=1. With id_two_src=0 -> no stall.
- branch_taken=1 together with a load-use hazard -> if_flush=1, id_bubble=1, if_freeze=0.
- mem_req=1, mem_ready low for 3 cycles, branch_taken pulsed in wait cycle 2 -> pipe_freeze=1 for 3 cycles, no flush during the wait. On the first cycle after mem_ready, if_flush=1. stall_cnt=3.
- mem_req=1, mem_ready held low -> pipe_freeze stays 1, ERR entered after 15 MEM_WAIT cycles, mem_timeout=1 sticky. rst pulse -> IDLE, mem_timeout=0, stall_cnt=0.
- Force stall_cnt near all-ones (CNT_W=4 build) with a continuous freeze -> holds at 15, no wrap.
